uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive-side counterpart to the team's UART transmitter. Samples an asynchronous serial line framed as 8N1, LSB first: one low start bit, eight data bits, one high stop bit, no parity. Delivers each received byte as a parallel word with a one-cycle valid pulse to the user_clk domain logic. Sits directly downstream of the transmitter, and the bench drives the receiver from it.

Parameters:
CLK_FREQUENCY, 66_000_000, user_clk frequency in Hz.
UART_FREQUENCY, 921_600, line bit rate in Hz; must match the transmitter.
(localparam) TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY (integer divide; 71 at defaults).
(localparam) HALF_BIT = TICKS_PER_BIT >> 1 (35 at defaults).

Ports:
user_clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low; clock user_clk.
rx_bit  input  1  asynchronous serial line, idles high.
data  output  8  last correctly framed byte; holds its value until the next good frame.
data_valid  output  1  one-cycle pulse; data is new on this cycle.
framing_error  output  1  one-cycle pulse; stop bit sampled low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: data=0, data_valid=0, framing_error=0, busy=0. Synchronizer flops=1, state=IDLE, counters=0.
- rx_bit passes through a 2-flop synchronizer, giving rx_sync. Only rx_sync is used internally.
- clk_count is 12 bits and bit_count is 3 bits. Both are zeroed on every state change.
- IDLE:
  - rx_sync==0 -> START.
- START (lasts HALF_BIT cycles):
  - At clk_count==HALF_BIT-1, rx_sync==1 -> IDLE (glitch rejected, no output pulse).
  - At clk_count==HALF_BIT-1, rx_sync==0 -> RX.
- RX:
  - At clk_count==TICKS_PER_BIT-1: shift rx_sync into shift_reg[bit_count] (LSB first), clear clk_count, increment bit_count.
  - The sample taken at bit_count==7 -> STOP.
- STOP:
  - At clk_count==TICKS_PER_BIT-1, rx_sync==1: data<=shift_reg, pulse data_valid, -> IDLE.
  - At clk_count==TICKS_PER_BIT-1, rx_sync==0: pulse framing_error, leave data unchanged, -> BREAK.
- BREAK:
  - Waits for rx_sync==1, then -> IDLE. A held-low line (break) never produces repeated frames.
- data_valid and framing_error are registered, high for exactly one cycle, and mutually exclusive.
- Latency from rx_bit falling edge to data_valid high = 3 + HALF_BIT + 9*TICKS_PER_BIT cycles (677 at defaults).
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is detected without loss.
- Unused state encodings -> IDLE.
- rst_n asserted mid-frame: everything returns to reset values immediately and no pulse is emitted. A partial frame still on the line after reset release is received as whatever it decodes to; no special handling.
- Baud mismatch is not detected except as a framing error.

Decomposition:
- Shared include uart_defs.vh, also used by the transmitter:
  - state encodings IDLE/START/RX/STOP/BREAK as 3-bit constants;
  - the TICKS_PER_BIT/HALF_BIT derivation.
- One sub-module, sync_2ff: 1-bit two-flop synchronizer with a reset-value parameter (1 here). It is reusable for any other asynchronous input.

Test Plan:
Bench parameters CLK_FREQUENCY=16, UART_FREQUENCY=1 (TICKS_PER_BIT=16, HALF_BIT=8, latency 155) unless noted.
1. Loopback: transmitter sends 0xA5 into rx_bit -> data_valid pulses once, data=0xA5, framing_error never asserts. Repeat for 0x00, 0xFF, 0x01, 0x80.
2. Glitch: rx_bit low for 4 cycles, then high -> busy high about 8 cycles, no data_valid/framing_error pulse, data unchanged.
3. Framing error: hand-driven frame 0x3C with stop bit low, then line held low 40 cycles, then high -> framing_error pulses once. data keeps its previous value, busy stays high until the line returns high, and there is no second pulse.
4. Back-to-back: bytes 0x12, 0x34, 0x56 sent with zero idle between frames -> three data_valid pulses 160 cycles apart, data correct each time.
5. Reset mid-frame: assert rst_n during bit 3 of 0x99 -> outputs 0 immediately. Then a clean 0x5A after release -> data=0x5A.
6. Default parameters (71/35): send 0xC3 -> data_valid exactly 677 cycles after the falling edge.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encodings and bit-timing derivation.
// Also reused by the transmitter so both ends agree on timing.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StRx    = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

  localparam int unsigned CntWidth = 12;

  function automatic int unsigned ticks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud_hz);
    return clk_hz / baud_hz;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus parallel byte output of the UART receiver.
interface uart_rx_if;
  logic       rx_bit;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  modport slave  (input rx_bit, output data, data_valid, framing_error, busy);
  modport master (output rx_bit, input data, data_valid, framing_error, busy);
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: mid-bit sampling, one-cycle data_valid / framing_error pulses,
// and break handling so a held-low line yields a single error.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = 66_000_000,
  parameter int unsigned UART_FREQUENCY = 921_600
) (
  input logic     user_clk,
  input logic     rst_n,
  uart_rx_if.slave rx_if
);

  localparam int unsigned TICKS_PER_BIT = ticks_per_bit(CLK_FREQUENCY, UART_FREQUENCY);
  localparam int unsigned HALF_BIT      = TICKS_PER_BIT >> 1;

  localparam logic [CntWidth-1:0] TickLast = CntWidth'(TICKS_PER_BIT - 1);
  localparam logic [CntWidth-1:0] HalfLast = CntWidth'(HALF_BIT - 1);

  logic rx_sync;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (user_clk),
    .rst_ni(rst_n),
    .d_i   (rx_if.rx_bit),
    .q_o   (rx_sync)
  );

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!rx_sync) state_d = StStart;
      end
      StStart: begin
        // Start bit must still be low at its midpoint, otherwise treat it as a glitch.
        if (clk_cnt_q == HalfLast) state_d = rx_sync ? StIdle : StRx;
      end
      StRx: begin
        if (clk_cnt_q == TickLast) begin
          shift_d[bit_cnt_q] = rx_sync;
          clk_cnt_d          = '0;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (clk_cnt_q == TickLast) begin
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        clk_cnt_d = '0;
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  assign rx_if.data          = data_q;
  assign rx_if.data_valid    = valid_q;
  assign rx_if.framing_error = ferr_q;
  assign rx_if.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: loopback, glitch, framing error, back-to-back,
// reset mid-frame, and latency at both the fast bench rate and default parameters.
module tb_uart_rx;

  localparam int Tpb  = 16;
  localparam int TpbD = 71;

  logic user_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;

  int n_chk  = 0;
  int n_pass = 0;

  int dv_cnt = 0, fe_cnt = 0, both_cnt = 0, dv_last = 0, dv_prev = 0;
  int dv_cnt_d = 0, dv_last_d = 0;
  int fall_cyc;
  int dv0, fe0;

  uart_rx_if bus ();
  uart_rx_if bus_d ();

  uart_rx #(
    .CLK_FREQUENCY (16),
    .UART_FREQUENCY(1)
  ) dut (
    .user_clk(user_clk),
    .rst_n   (rst_n),
    .rx_if   (bus)
  );

  uart_rx dut_dflt (
    .user_clk(user_clk),
    .rst_n   (rst_n),
    .rx_if   (bus_d)
  );

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  always @(negedge user_clk) begin
    if (bus.data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_prev <= dv_last;
      dv_last <= cyc;
    end
    if (bus.framing_error) fe_cnt <= fe_cnt + 1;
    if (bus.data_valid && bus.framing_error) both_cnt <= both_cnt + 1;
    if (bus_d.data_valid) begin
      dv_cnt_d  <= dv_cnt_d + 1;
      dv_last_d <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_line(input bit dflt, input logic v);
    if (dflt) bus_d.rx_bit = v;
    else bus.rx_bit = v;
  endtask

  // Behavioural transmitter: start, 8 data bits LSB first, stop; called at posedge+1.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int tpb,
                            input bit dflt);
    logic [9:0] frame;
    frame    = {stop_v, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      set_line(dflt, frame[i]);
      tick(tpb);
    end
  endtask

  initial begin
    logic [7:0] bytes [5];
    logic [7:0] b2b [3];
    bytes = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
    b2b   = '{8'h12, 8'h34, 8'h56};

    bus.rx_bit   = 1'b1;
    bus_d.rx_bit = 1'b1;
    tick(2);
    check("rst_data", {24'd0, bus.data}, 32'h0);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_ferr", {31'd0, bus.framing_error}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Loopback of several patterns, checking latency on the first.
    for (int i = 0; i < 5; i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(bytes[i], 1'b1, Tpb, 1'b0);
      check("loop_dv_count", dv_cnt - dv0, 32'd1);
      check("loop_fe_count", fe_cnt - fe0, 32'd0);
      check("loop_data", {24'd0, bus.data}, {24'd0, bytes[i]});
      if (i == 0) check("loop_latency", dv_last - fall_cyc, 32'd155);
      tick(3);
    end

    // Short low glitch on an idle line.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    bus.rx_bit = 1'b0;
    tick(4);
    bus.rx_bit = 1'b1;
    tick(2);
    check("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
    tick(20);
    check("glitch_busy_lo", {31'd0, bus.busy}, 32'd0);
    check("glitch_dv", dv_cnt - dv0, 32'd0);
    check("glitch_fe", fe_cnt - fe0, 32'd0);
    check("glitch_data", {24'd0, bus.data}, 32'h80);

    // Bad stop bit followed by a held-low line.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, Tpb, 1'b0);
    tick(40);
    check("ferr_pulse", fe_cnt - fe0, 32'd1);
    check("ferr_dv", dv_cnt - dv0, 32'd0);
    check("ferr_data", {24'd0, bus.data}, 32'h80);
    check("ferr_busy_hi", {31'd0, bus.busy}, 32'd1);
    bus.rx_bit = 1'b1;
    tick(6);
    check("ferr_busy_lo", {31'd0, bus.busy}, 32'd0);
    check("ferr_once", fe_cnt - fe0, 32'd1);
    tick(10);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(b2b[i], 1'b1, Tpb, 1'b0);
      check("b2b_data", {24'd0, bus.data}, {24'd0, b2b[i]});
      if (i > 0) check("b2b_spacing", dv_last - dv_prev, 32'd160);
    end
    check("b2b_count", dv_cnt - dv0, 32'd3);
    tick(5);

    // Reset during bit 3 of 0x99.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    bus.rx_bit = 1'b0;
    tick(Tpb);
    bus.rx_bit = 1'b1;
    tick(Tpb);
    bus.rx_bit = 1'b0;
    tick(2 * Tpb);
    bus.rx_bit = 1'b1;
    tick(8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, bus.data}, 32'h0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("mid_rst_ferr", {31'd0, bus.framing_error}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(40);
    send_frame(8'h5A, 1'b1, Tpb, 1'b0);
    check("post_rst_data", {24'd0, bus.data}, 32'h5A);
    check("post_rst_dv", dv_cnt - dv0, 32'd1);
    check("post_rst_fe", fe_cnt - fe0, 32'd0);

    // Default-parameter instance: 71/35 timing.
    dv0 = dv_cnt_d;
    send_frame(8'hC3, 1'b1, TpbD, 1'b1);
    check("dflt_count", dv_cnt_d - dv0, 32'd1);
    check("dflt_latency", dv_last_d - fall_cyc, 32'd677);
    check("dflt_data", {24'd0, bus_d.data}, 32'hC3);
    tick(5);

    check("never_both", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
